// File: rtl/game_timer_if.sv
// Control inputs and MM:SS display/status outputs of the game timer.
// The timer side takes the slave modport; whoever drives start/pause/game_over takes master.
interface game_timer_if;
    logic       start;
    logic       pause;
    logic       game_over;
    logic [3:0] sec_lo;
    logic [3:0] sec_hi;
    logic [3:0] min_lo;
    logic [3:0] min_hi;
    logic [1:0] state;
    logic       running;
    logic       time_up;

    modport master (
        output start, pause, game_over,
        input  sec_lo, sec_hi, min_lo, min_hi, state, running, time_up
    );

    modport slave (
        input  start, pause, game_over,
        output sec_lo, sec_hi, min_lo, min_hi, state, running, time_up
    );
endinterface

// File: rtl/game_timer.sv
// Elapsed-time counter for the runner game: BCD MM:SS advanced by a synchronized 1 Hz tick,
// with pause, collision freeze and an optional minute limit that ends the game.
module game_timer #(
    parameter int LIMIT_MIN   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_1s,
    game_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam bit         HAS_LIMIT = (LIMIT_MIN != 0);
    localparam logic [3:0] LIM_HI    = 4'(LIMIT_MIN / 10);
    localparam logic [3:0] LIM_LO    = 4'(LIMIT_MIN % 10);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   tick;

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;  // {min_hi, min_lo, sec_hi, sec_lo}
    logic [15:0] inc;
    logic        time_up_q, time_up_d;
    logic        running_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1s};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

    // BCD increment with carries; 99:59 rolls over to 00:00.
    always_comb begin
        inc = digits_q;
        if (digits_q[3:0] == 4'd9) begin
            inc[3:0] = 4'd0;
            if (digits_q[7:4] == 4'd5) begin
                inc[7:4] = 4'd0;
                if (digits_q[11:8] == 4'd9) begin
                    inc[11:8]  = 4'd0;
                    inc[15:12] = (digits_q[15:12] == 4'd9) ? 4'd0 : digits_q[15:12] + 4'd1;
                end else begin
                    inc[11:8] = digits_q[11:8] + 4'd1;
                end
            end else begin
                inc[7:4] = digits_q[7:4] + 4'd1;
            end
        end else begin
            inc[3:0] = digits_q[3:0] + 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        time_up_d = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d  = RUN;
                    digits_d = '0;
                end
            end
            RUN: begin
                if (bus.game_over) begin
                    state_d = OVER;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    digits_d = inc;
                    if (HAS_LIMIT && inc == {LIM_HI, LIM_LO, 8'h00}) begin
                        state_d   = OVER;
                        time_up_d = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (bus.game_over) begin
                    state_d = OVER;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            time_up_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            time_up_q <= time_up_d;
            running_q <= (state_d == RUN);
        end
    end

    assign bus.sec_lo  = digits_q[3:0];
    assign bus.sec_hi  = digits_q[7:4];
    assign bus.min_lo  = digits_q[11:8];
    assign bus.min_hi  = digits_q[15:12];
    assign bus.state   = state_q;
    assign bus.running = running_q;
    assign bus.time_up = time_up_q;

endmodule
